// File: rtl/write_back_unit.sv
// write_back_unit: final pipeline stage driving the register-file write port.
// Accepts execute results and single outstanding loads, extracts/extends load
// data, reports load errors/timeouts, and flags RAW hazards for two queries.
// Optional macro WB_FORWARD_EN adds forwarding of the write presented this cycle.
module write_back_unit #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_load_funct,
    input  logic [1:0]  ex_addr_low,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  destination_register_number,
    output logic [31:0] write_back_data,
    output logic        load_error,
    input  logic [4:0]  query_a,
    input  logic [4:0]  query_b,
`ifdef WB_FORWARD_EN
    output logic        forward_a_valid,
    output logic        forward_b_valid,
    output logic [31:0] forward_a_data,
    output logic [31:0] forward_b_data,
`endif
    output logic        hazard_a,
    output logic        hazard_b
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [REG_W-1:0]    cap_rd_q, cap_rd_d;
    logic [2:0]          cap_funct_q, cap_funct_d;
    logic [1:0]          cap_addr_q, cap_addr_d;
    logic                pending_q, pending_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;

    logic [7:0]          byte_c;
    logic [15:0]         half_c;
    logic [DATA_W-1:0]   load_data_c;
    logic                load_bad_c;
    logic                timeout_c;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cap_rd_q    <= '0;
            cap_funct_q <= '0;
            cap_addr_q  <= '0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cap_rd_q    <= cap_rd_d;
            cap_funct_q <= cap_funct_d;
            cap_addr_q  <= cap_addr_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
        end
    end

    // Lane selection, extension and legality of the captured load.
    always_comb begin
        byte_c      = 8'(mem_rdata >> {cap_addr_q, 3'b000});
        half_c      = cap_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data_c = '0;
        load_bad_c  = 1'b0;
        case (cap_funct_q)
            3'b000: load_data_c = {{24{byte_c[7]}}, byte_c};
            3'b001: begin
                load_data_c = {{16{half_c[15]}}, half_c};
                load_bad_c  = cap_addr_q[0];
            end
            3'b010: begin
                load_data_c = mem_rdata;
                load_bad_c  = (cap_addr_q != 2'b00);
            end
            3'b100: load_data_c = {24'b0, byte_c};
            3'b101: begin
                load_data_c = {16'b0, half_c};
                load_bad_c  = cap_addr_q[0];
            end
            default: load_bad_c = 1'b1;
        endcase
    end

    assign timeout_c = (cnt_q == TIMEOUT_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rd_d        = '0;
        data_d      = data_q;
        err_d       = 1'b0;
        cap_rd_d    = cap_rd_q;
        cap_funct_d = cap_funct_q;
        cap_addr_d  = cap_addr_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        cap_rd_d    = ex_rd;
                        cap_funct_d = ex_load_funct;
                        cap_addr_d  = ex_addr_low;
                        pending_d   = 1'b1;
                        cnt_d       = '0;
                        state_d     = WAIT_LOAD;
                    end else begin
                        rd_d   = ex_rd;
                        data_d = ex_result;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                    if (load_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d   = cap_rd_q;
                        data_d = load_data_c;
                    end
                end else if (timeout_c) begin
                    err_d     = 1'b1;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    assign ex_ready                    = (state_q == IDLE);
    assign destination_register_number = rd_q;
    assign write_back_data             = data_q;
    assign load_error                  = err_q;

`ifdef WB_FORWARD_EN
    // Current write is forwarded; only the pending load still stalls.
    always_comb begin
        forward_a_valid = (query_a != '0) && (query_a == rd_q);
        forward_b_valid = (query_b != '0) && (query_b == rd_q);
        forward_a_data  = data_q;
        forward_b_data  = data_q;
        hazard_a        = (query_a != '0) && pending_q && (query_a == cap_rd_q);
        hazard_b        = (query_b != '0) && pending_q && (query_b == cap_rd_q);
    end
`else
    // Stall on the pending load destination or the write presented this cycle.
    always_comb begin
        hazard_a = (query_a != '0) &&
                   ((pending_q && (query_a == cap_rd_q)) || (query_a == rd_q));
        hazard_b = (query_b != '0) &&
                   ((pending_q && (query_b == cap_rd_q)) || (query_b == rd_q));
    end
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Directed self-checking bench for write_back_unit.
module tb_write_back_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_load_funct;
    logic [1:0]  ex_addr_low;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_o;
    logic [31:0] data_o;
    logic        load_error;
    logic [4:0]  query_a;
    logic [4:0]  query_b;
    logic        hazard_a;
    logic        hazard_b;
`ifdef WB_FORWARD_EN
    logic        forward_a_valid;
    logic        forward_b_valid;
    logic [31:0] forward_a_data;
    logic [31:0] forward_b_data;
    localparam logic WR_HAZ = 1'b0;
`else
    localparam logic WR_HAZ = 1'b1;
`endif

    int errors = 0;
    int checks = 0;

    write_back_unit #(.LOAD_TIMEOUT(16), .TO_W(8)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .ex_valid                    (ex_valid),
        .ex_ready                    (ex_ready),
        .ex_rd                       (ex_rd),
        .ex_result                   (ex_result),
        .ex_is_load                  (ex_is_load),
        .ex_load_funct               (ex_load_funct),
        .ex_addr_low                 (ex_addr_low),
        .mem_rvalid                  (mem_rvalid),
        .mem_rdata                   (mem_rdata),
        .destination_register_number (rd_o),
        .write_back_data             (data_o),
        .load_error                  (load_error),
        .query_a                     (query_a),
        .query_b                     (query_b),
`ifdef WB_FORWARD_EN
        .forward_a_valid             (forward_a_valid),
        .forward_b_valid             (forward_b_valid),
        .forward_a_data              (forward_a_data),
        .forward_b_data              (forward_b_data),
`endif
        .hazard_a                    (hazard_a),
        .hazard_b                    (hazard_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a load request for one cycle at a negedge.
    task automatic issue_load(input logic [2:0] funct, input logic [4:0] rd, input logic [1:0] al);
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_load_funct = funct;
        ex_rd = rd; ex_addr_low = al;
        @(negedge clk);
        ex_valid = 1'b0; ex_is_load = 1'b0;
    endtask

    // Issue a load, answer after dly wait cycles, return at the negedge after the write edge.
    task automatic do_load(input logic [2:0] funct, input logic [4:0] rd, input logic [1:0] al,
                           input int dly, input logic [31:0] rdata);
        issue_load(funct, rd, al);
        repeat (dly) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 0; ex_rd = 0; ex_result = 0; ex_is_load = 0;
        ex_load_funct = 0; ex_addr_low = 0; mem_rvalid = 0; mem_rdata = 0;
        query_a = 0; query_b = 0;
        #23;
        checks++;
        if (rd_o !== 5'd0 || data_o !== 32'd0 || load_error !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: rd=%0d data=%h err=%b ready=%b, want 0/0/0/1", rd_o, data_o, load_error, ex_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_write();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 0; ex_rd = 5'd5; ex_result = 32'h1234_5678; query_a = 5'd5;
        #1;
        checks++;
        if (hazard_a !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_pre: hazard_a=%b ready=%b, want 0/1", hazard_a, ex_ready);
        end
        @(negedge clk); ex_valid = 0; #1;
        checks++;
        if (rd_o !== 5'd5 || data_o !== 32'h1234_5678 || hazard_a !== WR_HAZ) begin
            errors++;
            $display("FAIL write: rd=%0d data=%h hazard_a=%b, want 5/12345678/%b", rd_o, data_o, hazard_a, WR_HAZ);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_o !== 5'd0 || data_o !== 32'h1234_5678 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL write_after: rd=%0d data=%h hazard_a=%b, want 0/12345678/0", rd_o, data_o, hazard_a);
        end
        query_a = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (i > 0) begin
                checks++;
                if (rd_o !== 5'(i) || data_o !== (32'hC0DE_0000 + 32'(i))) begin
                    errors++;
                    $display("FAIL b2b[%0d]: rd=%0d data=%h, want %0d/%h", i, rd_o, data_o, i, 32'hC0DE_0000 + 32'(i));
                end
            end
            if (i < 3) begin
                ex_valid = 1; ex_is_load = 0; ex_rd = 5'(i + 1); ex_result = 32'hC0DE_0001 + 32'(i);
            end else begin
                ex_valid = 0;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rd_o !== 5'd0) begin
            errors++;
            $display("FAIL b2b_end: rd=%0d, want 0", rd_o);
        end
    endtask

    task automatic test_load_lb();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 1; ex_load_funct = 3'b000; ex_rd = 5'd3; ex_addr_low = 2'd2;
        query_a = 5'd3;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            // non-load request held during the wait must be ignored
            ex_is_load = 0; ex_rd = 5'd9; ex_result = 32'hBAD0_BAD0;
            if (i == 5) begin
                ex_valid = 0; mem_rvalid = 1; mem_rdata = 32'h0080_0000;
            end
            #1;
            checks++;
            if (ex_ready !== 1'b0 || hazard_a !== 1'b1 || rd_o !== 5'd0) begin
                errors++;
                $display("FAIL lb_wait[%0d]: ready=%b hazard_a=%b rd=%0d, want 0/1/0", i, ex_ready, hazard_a, rd_o);
            end
        end
        @(negedge clk); mem_rvalid = 0; #1;
        checks++;
        if (rd_o !== 5'd3 || data_o !== 32'hFFFF_FF80 || ex_ready !== 1'b1 || hazard_a !== WR_HAZ) begin
            errors++;
            $display("FAIL lb_write: rd=%0d data=%h ready=%b hz=%b, want 3/ffffff80/1/%b", rd_o, data_o, ex_ready, hazard_a, WR_HAZ);
        end
        @(negedge clk); #1;
        checks++;
        if (rd_o !== 5'd0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL lb_after: rd=%0d hazard_a=%b, want 0/0", rd_o, hazard_a);
        end
        query_a = 0;
    endtask

    task automatic test_load_extract();
        logic [2:0]  fn  [10] = '{3'b101, 3'b001, 3'b001, 3'b100, 3'b000, 3'b010, 3'b010, 3'b011, 3'b110, 3'b101};
        logic [1:0]  al  [10] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
        logic [31:0] rdt [10] = '{32'hBEEF_0000, 32'h1111_2222, 32'h0000_8001, 32'h8012_3456, 32'h0000_7F00,
                                  32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        logic [31:0] exp [10] = '{32'h0000_BEEF, 32'h0, 32'hFFFF_8001, 32'h0000_0080, 32'h0000_007F,
                                  32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        bad [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] prev;
        prev = data_o;
        for (int i = 0; i < 10; i++) begin
            do_load(fn[i], 5'(10 + i), al[i], i % 3, rdt[i]);
            checks++;
            if (bad[i]) begin
                if (load_error !== 1'b1 || rd_o !== 5'd0 || data_o !== prev || ex_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL extract_err[%0d]: err=%b rd=%0d data=%h ready=%b, want 1/0/%h/1", i, load_error, rd_o, data_o, ex_ready, prev);
                end
            end else begin
                if (load_error !== 1'b0 || rd_o !== 5'(10 + i) || data_o !== exp[i]) begin
                    errors++;
                    $display("FAIL extract[%0d]: err=%b rd=%0d data=%h, want 0/%0d/%h", i, load_error, rd_o, data_o, 10 + i, exp[i]);
                end
                prev = exp[i];
            end
        end
        @(negedge clk); #1;
        checks++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b, want 0", load_error);
        end
    endtask

    task automatic test_timeout();
        bit bad_wait;
        bad_wait = 0;
        query_a = 5'd12;
        issue_load(3'b010, 5'd12, 2'd0);
        #1;
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) begin @(negedge clk); #1; end
            if (load_error !== 1'b0 || ex_ready !== 1'b0 || hazard_a !== 1'b1) bad_wait = 1;
        end
        checks++;
        if (bad_wait) begin
            errors++;
            $display("FAIL timeout_wait: early exit or missing hazard (err=%b ready=%b hz=%b)", load_error, ex_ready, hazard_a);
        end
        @(negedge clk); #1;
        checks++;
        if (load_error !== 1'b1 || ex_ready !== 1'b1 || rd_o !== 5'd0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL timeout: err=%b ready=%b rd=%0d hz=%b, want 1/1/0/0", load_error, ex_ready, rd_o, hazard_a);
        end
        mem_rvalid = 1; mem_rdata = 32'hFACE_FACE;
        @(negedge clk); mem_rvalid = 0; #1;
        checks++;
        if (rd_o !== 5'd0 || load_error !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_rvalid: rd=%0d err=%b ready=%b, want 0/0/1", rd_o, load_error, ex_ready);
        end
        query_a = 0;
    endtask

    task automatic test_timeout_race();
        do_load(3'b010, 5'd13, 2'd0, 15, 32'h1313_1313);
        checks++;
        if (rd_o !== 5'd13 || data_o !== 32'h1313_1313 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_race: rd=%0d data=%h err=%b, want 13/13131313/0", rd_o, data_o, load_error);
        end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 0; ex_rd = 5'd0; ex_result = 32'h0F0F_0F0F; query_a = 5'd0; query_b = 5'd0;
        @(negedge clk); ex_valid = 0; #1;
        checks++;
        if (rd_o !== 5'd0 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL rd0_write: rd=%0d hz=%b%b, want 0/00", rd_o, hazard_a, hazard_b);
        end
        issue_load(3'b010, 5'd0, 2'd0);
        #1;
        checks++;
        if (ex_ready !== 1'b0 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL rd0_load_wait: ready=%b hz=%b, want 0/0", ex_ready, hazard_a);
        end
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        @(negedge clk); mem_rvalid = 0; #1;
        checks++;
        if (rd_o !== 5'd0 || load_error !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_load: rd=%0d err=%b ready=%b, want 0/0/1", rd_o, load_error, ex_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        query_a = 5'd14;
        issue_load(3'b010, 5'd14, 2'd0);
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (hazard_a !== 1'b1 || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: hz=%b ready=%b, want 1/0", hazard_a, ex_ready);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (rd_o !== 5'd0 || data_o !== 32'd0 || load_error !== 1'b0 || ex_ready !== 1'b1 || hazard_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rd=%0d data=%h err=%b ready=%b hz=%b, want 0/0/0/1/0", rd_o, data_o, load_error, ex_ready, hazard_a);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h1414_1414;
        @(negedge clk); mem_rvalid = 0; #1;
        checks++;
        if (rd_o !== 5'd0 || data_o !== 32'd0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rvalid: rd=%0d data=%h err=%b, want 0/0/0", rd_o, data_o, load_error);
        end
        query_a = 0;
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        @(negedge clk);
        ex_valid = 1; ex_is_load = 0; ex_rd = 5'd9; ex_result = 32'hA5A5_A5A5; query_b = 5'd9; query_a = 5'd0;
        @(negedge clk); ex_valid = 0; #1;
        checks++;
        if (forward_b_valid !== 1'b1 || forward_b_data !== 32'hA5A5_A5A5 || hazard_b !== 1'b0 || forward_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL forward: fb_v=%b fb_d=%h hz_b=%b fa_v=%b, want 1/a5a5a5a5/0/0", forward_b_valid, forward_b_data, hazard_b, forward_a_valid);
        end
        issue_load(3'b010, 5'd9, 2'd0);
        #1;
        checks++;
        if (hazard_b !== 1'b1 || forward_b_valid !== 1'b0) begin
            errors++;
            $display("FAIL forward_pending: hz_b=%b fb_v=%b, want 1/0", hazard_b, forward_b_valid);
        end
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'h0909_0909;
        @(negedge clk); mem_rvalid = 0; #1;
        checks++;
        if (forward_b_valid !== 1'b1 || forward_b_data !== 32'h0909_0909 || hazard_b !== 1'b0) begin
            errors++;
            $display("FAIL forward_load: fb_v=%b fb_d=%h hz_b=%b, want 1/09090909/0", forward_b_valid, forward_b_data, hazard_b);
        end
        query_b = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_load_lb();
        test_load_extract();
        test_timeout();
        test_timeout_race();
        test_rd_zero();
        test_reset_mid_load();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
